// File: rtl/phoenix_encoder_pkg.sv
// Shared types and constants for the quadrature encoder path: the signed
// step type produced by the transition decoder and the forward Gray order.
package phoenix_encoder_pkg;

  // One decoded movement: -1, 0 or +1, two's complement in two bits.
  typedef logic signed [1:0] step_t;

  localparam step_t STEP_NONE = 2'sb00;
  localparam step_t STEP_FWD  = 2'sb01;
  localparam step_t STEP_REV  = 2'sb11;

  // Forward rotation visits {A,B} in this order and wraps S3 -> S0.
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  // Decoder output bundle, handy when the pair is routed together.
  typedef struct packed {
    step_t step;
    logic  illegal;
  } step_result_t;

  // Next state one forward step after ab.
  function automatic logic [1:0] gray_fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      GRAY_S0: nxt = GRAY_S1;
      GRAY_S1: nxt = GRAY_S2;
      GRAY_S2: nxt = GRAY_S3;
      default: nxt = GRAY_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quadrature_step_decode.sv
// Pure combinational transition decoder: maps the previous and current
// {A,B} phase pair to a signed step and flags a two-bit jump as illegal.
module quadrature_step_decode
  import phoenix_encoder_pkg::*;
(
  input  logic [1:0] prev_ab,
  input  logic [1:0] cur_ab,
  output step_t      step,
  output logic       illegal
);

  step_result_t result;

  // A single-bit change is a step in the direction given by the Gray
  // order; no change is a rest; both bits changing has no defined sense.
  always_comb begin
    result.step    = STEP_NONE;
    result.illegal = 1'b0;
    if (cur_ab == prev_ab) begin
      result.step = STEP_NONE;
    end else if (cur_ab == gray_fwd_next(prev_ab)) begin
      result.step = STEP_FWD;
    end else if (prev_ab == gray_fwd_next(cur_ab)) begin
      result.step = STEP_REV;
    end else begin
      result.illegal = 1'b1;
    end
  end

  assign step    = result.step;
  assign illegal = result.illegal;

endmodule

// File: rtl/quadrature_decoder.sv
// 4x quadrature decoder: wrapping position counter, saturating per-window
// step count (velocity), last-direction flag and sticky illegal-jump flag.
module quadrature_decoder
  import phoenix_encoder_pkg::*;
#(
  parameter int POSITION_WIDTH = 16,
  parameter int VELOCITY_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic                      enc_a,
  input  logic                      enc_b,
  input  logic                      sample,
  input  logic                      clear_error,
  output logic [POSITION_WIDTH-1:0] position,
  output logic [VELOCITY_WIDTH-1:0] velocity,
  output logic                      velocity_valid,
  output logic                      direction,
  output logic                      error
);

  localparam int PW = POSITION_WIDTH;
  localparam int VW = VELOCITY_WIDTH;

  // Saturation limits of the window accumulator (two's complement).
  localparam logic [VW-1:0] ACC_MAX = {1'b0, {(VW-1){1'b1}}};
  localparam logic [VW-1:0] ACC_MIN = {1'b1, {(VW-1){1'b0}}};

  logic [1:0]    cur_ab;
  logic [1:0]    prev_ab_reg;
  logic          init_reg;
  logic [PW-1:0] position_reg;
  logic [PW-1:0] position_next;
  logic [VW-1:0] accum_reg;
  logic [VW-1:0] accum_sat;
  logic [VW:0]   accum_wide;
  logic [VW-1:0] velocity_reg;
  logic          velocity_valid_reg;
  logic          direction_reg;
  logic          error_reg;

  step_t         step_raw;
  logic          illegal_raw;
  step_t         step_eff;
  logic          illegal_eff;
  logic          decode_live;

  assign cur_ab = {enc_a, enc_b};

  quadrature_step_decode u_step_decode (
    .prev_ab (prev_ab_reg),
    .cur_ab  (cur_ab),
    .step    (step_raw),
    .illegal (illegal_raw)
  );

  // Transitions only count on enabled cycles once a reference state exists;
  // the first enabled cycle after reset merely captures that reference.
  assign decode_live = clk_en && init_reg;
  assign step_eff    = decode_live ? step_raw : STEP_NONE;
  assign illegal_eff = decode_live && illegal_raw;

  // Position wraps naturally at 2^PW in both directions.
  assign position_next = position_reg + {{(PW-2){step_eff[1]}}, step_eff};

  // Accumulate one bit wider, then clamp: a +/-1 step can overshoot the
  // signed range by at most one, visible as disagreeing top two bits.
  always_comb begin
    accum_wide = {accum_reg[VW-1], accum_reg} + {{(VW-1){step_eff[1]}}, step_eff};
    accum_sat  = accum_wide[VW-1:0];
    if (accum_wide[VW] != accum_wide[VW-1]) begin
      accum_sat = accum_wide[VW] ? ACC_MIN : ACC_MAX;
    end
  end

  // Reference phase pair and the "reference captured" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab_reg <= GRAY_S0;
      init_reg    <= 1'b0;
    end else if (clk_en) begin
      prev_ab_reg <= cur_ab;
      init_reg    <= 1'b1;
    end
  end

  // Position counter follows every decoded step one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position_reg <= '0;
    end else begin
      position_reg <= position_next;
    end
  end

  // Window accumulator: restarts from zero whenever a window is closed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum_reg <= '0;
    end else if (sample) begin
      accum_reg <= '0;
    end else begin
      accum_reg <= accum_sat;
    end
  end

  // Velocity latches the closing window, including the closing cycle's step;
  // the valid pulse lands in the same cycle the new value becomes visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      velocity_reg       <= '0;
      velocity_valid_reg <= 1'b0;
    end else begin
      velocity_valid_reg <= sample;
      if (sample) begin
        velocity_reg <= accum_sat;
      end
    end
  end

  // Direction tracks the sign of the most recent nonzero step only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      direction_reg <= 1'b0;
    end else if (step_eff != STEP_NONE) begin
      direction_reg <= step_eff[1];
    end
  end

  // Sticky error: a new illegal jump outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_reg <= 1'b0;
    end else if (illegal_eff) begin
      error_reg <= 1'b1;
    end else if (clear_error) begin
      error_reg <= 1'b0;
    end
  end

  assign position       = position_reg;
  assign velocity       = velocity_reg;
  assign velocity_valid = velocity_valid_reg;
  assign direction      = direction_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a 16/16 instance plus a 16/4
// instance sharing the same stimulus for the velocity saturation cases.
module tb_quadrature_decoder;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        enc_a;
  logic        enc_b;
  logic        sample;
  logic        clear_error;

  logic [15:0] position;
  logic [15:0] velocity;
  logic        velocity_valid;
  logic        direction;
  logic        error;

  logic [15:0] v4_position;
  logic [3:0]  v4_velocity;
  logic        v4_velocity_valid;
  logic        v4_direction;
  logic        v4_error;

  int compared;
  int mismatched;
  logic [1:0] ab;

  quadrature_decoder #(.POSITION_WIDTH(16), .VELOCITY_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_en         (clk_en),
    .enc_a          (enc_a),
    .enc_b          (enc_b),
    .sample         (sample),
    .clear_error    (clear_error),
    .position       (position),
    .velocity       (velocity),
    .velocity_valid (velocity_valid),
    .direction      (direction),
    .error          (error)
  );

  quadrature_decoder #(.POSITION_WIDTH(16), .VELOCITY_WIDTH(4)) dut_v4 (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_en         (clk_en),
    .enc_a          (enc_a),
    .enc_b          (enc_b),
    .sample         (sample),
    .clear_error    (clear_error),
    .position       (v4_position),
    .velocity       (v4_velocity),
    .velocity_valid (v4_velocity_valid),
    .direction      (v4_direction),
    .error          (v4_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_ab(input logic [1:0] s);
    ab    = s;
    enc_a = s[1];
    enc_b = s[0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset_n     = 1'b0;
    clk_en      = 1'b0;
    sample      = 1'b0;
    clear_error = 1'b0;
    set_ab(2'b00);
    tick(3);
    check("reset_position", position, 32'h0);
    check("reset_velocity", velocity, 32'h0);
    check("reset_valid", velocity_valid, 32'h0);
    check("reset_direction", direction, 32'h0);
    check("reset_error", error, 32'h0);

    // Forward cycle, one state per 4 cycles.
    reset_n = 1'b1;
    clk_en  = 1'b1;
    tick(4);
    set_ab(2'b01); tick(4);
    set_ab(2'b11); tick(4);
    set_ab(2'b10); tick(4);
    set_ab(2'b00); tick(4);
    check("fwd_position", position, 32'h0004);
    check("fwd_direction", direction, 32'h0);
    check("fwd_error", error, 32'h0);

    // Reverse cycle from a fresh zero position.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    set_ab(2'b10); tick(4);
    set_ab(2'b11); tick(4);
    set_ab(2'b01); tick(4);
    set_ab(2'b00); tick(4);
    check("rev_position", position, 32'hFFFC);
    check("rev_direction", direction, 32'h1);
    check("rev_error", error, 32'h0);

    // Illegal jump 00 -> 11.
    set_ab(2'b11); tick(1);
    check("illegal_error", error, 32'h1);
    check("illegal_position", position, 32'hFFFC);
    check("illegal_direction", direction, 32'h1);

    // Clear together with a second illegal jump: set wins.
    set_ab(2'b00);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check("set_wins_error", error, 32'h1);
    check("set_wins_position", position, 32'hFFFC);

    // Lone clear.
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    check("clear_error", error, 32'h0);

    // Close the reverse window: -4.
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    check("win_rev_velocity", velocity, 32'hFFFC);
    check("win_rev_valid", velocity_valid, 32'h1);
    check("win_rev_v4_velocity", v4_velocity, 32'hC);
    tick(1);
    check("win_rev_valid_drop", velocity_valid, 32'h0);

    // Ten forward steps, then sample together with an eleventh.
    for (int i = 0; i < 10; i++) begin
      set_ab(fwd(ab));
      tick(1);
    end
    check("pre_sample_valid", velocity_valid, 32'h0);
    set_ab(fwd(ab));
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    check("vel11_velocity", velocity, 32'h000B);
    check("vel11_valid", velocity_valid, 32'h1);
    check("vel11_v4_sat", v4_velocity, 32'h7);
    check("vel11_position", position, 32'h0007);
    tick(1);
    check("vel11_valid_once", velocity_valid, 32'h0);
    check("vel11_velocity_hold", velocity, 32'h000B);

    // Empty window, then a back-to-back strobe.
    sample = 1'b1;
    tick(1);
    check("empty_velocity", velocity, 32'h0);
    check("empty_valid", velocity_valid, 32'h1);
    tick(1);
    sample = 1'b0;
    check("b2b_velocity", velocity, 32'h0);
    check("b2b_valid", velocity_valid, 32'h1);
    tick(1);
    check("b2b_valid_drop", velocity_valid, 32'h0);

    // Nine forward steps: 4-bit velocity saturates at +7.
    for (int i = 0; i < 9; i++) begin
      set_ab(fwd(ab));
      tick(1);
    end
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    check("sat_pos_velocity", velocity, 32'h0009);
    check("sat_pos_v4_velocity", v4_velocity, 32'h7);
    check("sat_pos_v4_valid", v4_velocity_valid, 32'h1);
    check("sat_pos_v4_position", v4_position, 32'h0010);
    check("sat_pos_v4_direction", v4_direction, 32'h0);
    check("sat_pos_v4_error", v4_error, 32'h0);
    check("sat_pos_position", position, 32'h0010);

    // Nine reverse steps: 4-bit velocity saturates at -8.
    for (int i = 0; i < 9; i++) begin
      set_ab(rev(ab));
      tick(1);
    end
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    check("sat_neg_velocity", velocity, 32'hFFF7);
    check("sat_neg_v4_velocity", v4_velocity, 32'h8);
    check("sat_neg_position", position, 32'h0007);
    check("sat_neg_direction", direction, 32'h1);

    // Partial window, then asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      set_ab(fwd(ab));
      tick(1);
    end
    check("partial_position", position, 32'h000A);
    reset_n = 1'b0;
    #1;
    check("async_position", position, 32'h0);
    check("async_velocity", velocity, 32'h0);
    check("async_valid", velocity_valid, 32'h0);
    check("async_direction", direction, 32'h0);
    check("async_error", error, 32'h0);
    tick(2);
    reset_n = 1'b1;

    // First enabled cycle after reset with AB=11: reference load only.
    check("relaunch_ab", ab, 32'h3);
    tick(1);
    check("relaunch_position", position, 32'h0);
    check("relaunch_error", error, 32'h0);
    check("relaunch_direction", direction, 32'h0);
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    check("discard_velocity", velocity, 32'h0);
    check("discard_valid", velocity_valid, 32'h1);

    // clk_en low ignores the encoder; re-enabling decodes against the old reference.
    clk_en = 1'b0;
    set_ab(2'b10);
    tick(2);
    check("gated_position", position, 32'h0);
    clk_en = 1'b1;
    tick(1);
    check("ungated_position", position, 32'h0001);

    // Walk up to 0x7FFF, then cross into 0x8000.
    for (int i = 0; i < 32766; i++) begin
      set_ab(fwd(ab));
      tick(1);
    end
    check("walk_position", position, 32'h7FFF);
    set_ab(fwd(ab));
    tick(1);
    check("wrap_position", position, 32'h8000);
    check("wrap_direction", direction, 32'h0);
    check("wrap_error", error, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter POSITION_WIDTH, default 16: width of the wrapping position counter.
REQ-002 Parameter VELOCITY_WIDTH, default 16: width of the saturating per-window step count.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port clk_en, input, 1: qualifies enc_a/enc_b sampling; held-off cycles ignore the encoder inputs.
REQ-006 Port enc_a, input, 1: encoder phase A, already synchronized and deglitched upstream.
REQ-007 Port enc_b, input, 1: encoder phase B, already synchronized and deglitched upstream.
REQ-008 Port sample, input, 1: one-cycle strobe that closes a velocity window; not gated by clk_en.
REQ-009 Port clear_error, input, 1: one-cycle strobe that clears the sticky error flag.
REQ-010 Port position, output, POSITION_WIDTH: signed 4x-decoded position.
REQ-011 Port velocity, output, VELOCITY_WIDTH: signed step count of the last closed window.
REQ-012 Port velocity_valid, output, 1: one-cycle pulse marking a new velocity value.
REQ-013 Port direction, output, 1: sign of the last nonzero step; 0 means forward (+1), 1 means reverse (-1).
REQ-014 Port error, output, 1: sticky illegal-transition flag.

Function
REQ-015 On each clk_en cycle the block SHALL compare {enc_a,enc_b} with the stored previous state prev_ab, then update prev_ab.
REQ-016 Forward sequence 00->01->11->10->00 SHALL give step +1.
REQ-017 The reverse of that sequence SHALL give step -1.
REQ-018 An unchanged state SHALL give step 0.
REQ-019 A change of both bits in one sample SHALL give step 0 and set error.
REQ-020 The first clk_en cycle after reset SHALL only load prev_ab, with no step and no error.
REQ-021 position SHALL reflect a step one clk cycle after the sampling clk_en cycle.
REQ-022 position SHALL wrap modulo 2^POSITION_WIDTH in both directions (max+1 -> min, min-1 -> max).
REQ-023 direction SHALL update on every nonzero step.
REQ-024 direction SHALL hold its value on zero steps and on error events.
REQ-025 A window accumulator SHALL sum steps.
REQ-026 The accumulator SHALL saturate at +(2^(VELOCITY_WIDTH-1)-1) and -(2^(VELOCITY_WIDTH-1)).
REQ-027 When sample=1, velocity SHALL load the accumulator value including that cycle's step (saturated), and velocity_valid SHALL pulse high on the following cycle, aligned with the new velocity value.
REQ-028 When sample=1, the accumulator SHALL restart at 0.
REQ-029 Back-to-back sample strobes SHALL yield a valid pulse per strobe; a window with no steps reports 0.
REQ-030 error SHALL stay high until clear_error.
REQ-031 If an illegal transition and clear_error occur in the same cycle, error SHALL remain 1 (set wins).

Reset
REQ-032 While reset_n=0: position=0, velocity=0, velocity_valid=0, direction=0, error=0, accumulator=0, prev_ab=00, init flag cleared.
REQ-033 Reset asserted mid-window SHALL discard the partial accumulation.
REQ-034 After reset_n deasserts, the first clk_en cycle SHALL behave per REQ-020.

Structure
REQ-035 Package phoenix_encoder_pkg SHALL hold the step typedef (2-bit signed: -1/0/+1) and the forward Gray-sequence constants.
REQ-036 Sub-module quadrature_step_decode SHALL be a purely combinational mapping of (prev_ab, cur_ab) to (step, illegal).
REQ-037 All remaining logic (counters, saturation, flags) SHALL live in quadrature_decoder.

Verification
REQ-038 Reset, clk_en=1, A/B stepped 00,01,11,10,00 (one state per 4 cycles) -> position=4, direction=0, error=0.
REQ-039 Same sequence reversed from position 0 -> position 0xFFFC (16-bit), direction=1.
REQ-040 AB 00->11 in one sample -> error=1, position unchanged.
REQ-041 Then clear_error and a second illegal transition in the same cycle -> error stays 1.
REQ-042 Then a lone clear_error -> error=0.
REQ-043 10 forward steps, then sample with a forward step in the same cycle -> velocity=11 and velocity_valid pulses once, one cycle later.
REQ-044 Next sample with no steps -> velocity=0.
REQ-045 VELOCITY_WIDTH=4, 9 forward steps, then sample -> velocity=7 (saturated).
REQ-046 Position preloaded to 0x7FFF by stimulus, +1 step -> 0x8000.
REQ-047 reset_n pulsed low mid-window -> all outputs 0.
REQ-048 After reset release, the first clk_en with AB=11 -> no step and no error.
